// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx
//   Per-lane receive deserializer feeding the lane unstriper. Hunts for the
//   COM symbol at any bit offset, declares byte alignment after LOCK_COUNT
//   consecutive byte-aligned COMs, then packs every four non-COM bytes into a
//   32-bit word (first byte in [31:24]).
//
// Ports
//   clk_32f    in   1   bit clock, rising edge
//   reset_L    in   1   asynchronous active-low reset
//   data_in    in   1   serial data, MSB of each byte first
//   data_out   out  32  last assembled word
//   valid_out  out  1   data_out holds a word not yet superseded by idle
//   active     out  1   byte alignment locked
//   dbg_state  out  2   current FSM state (0 SEARCH, 1 ALIGN, 2 LOCKED)
//
// Handshake: no backpressure. valid_out is a level; a new word is delivered
// on every edge where data_out is loaded with valid_out<=1. The consumer must
// take each word within 32 clk_32f cycles.

module serial_paralelo_rx #(
   parameter logic [7:0]  COM        = 8'hBC,
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic        clk_32f,
   input  logic        reset_L,
   input  logic        data_in,
   output logic [31:0] data_out,
   output logic        valid_out,
   output logic        active,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_SEARCH = 2'd0,
      S_ALIGN  = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LC = LOCK_COUNT[3:0];

   state_t      r_state;
   logic [7:0]  r_sr;
   logic [2:0]  r_bit_cnt;
   logic [3:0]  r_com_cnt;
   logic [1:0]  r_byte_idx;
   logic [31:0] r_buf;

   logic [7:0]  w_byte_now;
   logic        w_boundary;
   logic        w_is_com;

   // The byte ending on this edge includes the bit being sampled now.
   assign w_byte_now = {r_sr[6:0], data_in};
   assign w_boundary = (r_bit_cnt == 3'd7);
   assign w_is_com   = (w_byte_now == COM);
   assign dbg_state  = r_state;

   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         r_state    <= S_SEARCH;
         r_sr       <= 8'd0;
         r_bit_cnt  <= 3'd0;
         r_com_cnt  <= 4'd0;
         r_byte_idx <= 2'd0;
         r_buf      <= 32'd0;
         data_out   <= 32'd0;
         valid_out  <= 1'b0;
         active     <= 1'b0;
      end else begin
         r_sr <= w_byte_now;
         case (r_state)
            S_SEARCH: begin
               // Bit-by-bit hunt: a COM here fixes the byte phase, so the
               // next boundary falls exactly 8 edges later.
               if (w_is_com) begin
                  r_bit_cnt <= 3'd0;
                  r_com_cnt <= 4'd1;
                  if (LC == 4'd1) begin
                     r_state <= S_LOCKED;
                     active  <= 1'b1;
                  end else begin
                     r_state <= S_ALIGN;
                  end
               end
            end

            S_ALIGN: begin
               r_bit_cnt <= r_bit_cnt + 3'd1;
               if (w_boundary) begin
                  if (w_is_com) begin
                     if (r_com_cnt + 4'd1 >= LC) begin
                        r_com_cnt <= LC;     // saturate
                        r_state   <= S_LOCKED;
                        active    <= 1'b1;
                     end else begin
                        r_com_cnt <= r_com_cnt + 4'd1;
                     end
                  end else begin
                     r_com_cnt <= 4'd0;
                     r_state   <= S_SEARCH;
                  end
               end
            end

            S_LOCKED: begin
               r_bit_cnt <= r_bit_cnt + 3'd1;
               if (w_boundary) begin
                  if (w_is_com) begin
                     // Idle: drop any partial word, keep last data visible.
                     r_byte_idx <= 2'd0;
                     valid_out  <= 1'b0;
                  end else begin
                     case (r_byte_idx)
                        2'd0: r_buf[31:24] <= w_byte_now;
                        2'd1: r_buf[23:16] <= w_byte_now;
                        2'd2: r_buf[15:8]  <= w_byte_now;
                        default: r_buf[7:0] <= w_byte_now;
                     endcase
                     if (r_byte_idx == 2'd3) begin
                        data_out  <= {r_buf[31:8], w_byte_now};
                        valid_out <= 1'b1;
                     end
                     r_byte_idx <= r_byte_idx + 2'd1;   // wraps 3->0
                  end
               end
            end

            default: begin
               r_state <= S_SEARCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
module tb_serial_paralelo_rx;

  localparam logic [7:0] COM = 8'hBC;

  // ---------------- clock / reset ----------------
  logic        clk_32f = 1'b0;
  logic        reset_L = 1'b0;
  logic        data_in = 1'b0;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active;
  logic [1:0]  dbg_state;

  always #5 clk_32f = ~clk_32f;

  serial_paralelo_rx dut (
    .clk_32f  (clk_32f),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_words  = 0;

  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one bit 1 time unit after an edge, return 1 unit after the edge
  // that samples it.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_7(input logic [7:0] b);
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  // ---------------- monitor / scoreboard ----------------
  // A word is presented when valid_out rises or data_out changes while valid.
  logic        prev_v = 1'b0;
  logic [31:0] prev_d = 32'd0;
  initial begin
    forever begin
      @(posedge clk_32f);
      #2;
      if (reset_L) begin
        if (valid_out && (!prev_v || data_out != prev_d)) begin
          n_words++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got %h expected none", data_out);
          end else begin
            check("word", data_out, exp_q.pop_front());
          end
        end
      end
      prev_v = valid_out;
      prev_d = data_out;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk_32f);
    #1;
    check("rst_data", data_out, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    reset_L = 1'b1;

    // Lock with a 3-bit offset
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int k = 0; k < 3; k++) send_byte(COM);
    check("align_active_3com", {31'd0, active}, 32'd0);
    send_7(COM);
    check("align_active_pre", {31'd0, active}, 32'd0);
    send_bit(COM[0]);
    check("lock_active", {31'd0, active}, 32'd1);
    check("lock_valid", {31'd0, valid_out}, 32'd0);
    check("lock_state", {30'd0, dbg_state}, 32'd2);

    // Word assembly
    exp_q.push_back(32'hDEADBEEF);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
    check("partial_valid", {31'd0, valid_out}, 32'd0);
    send_7(8'hEF);
    check("pre_word_valid", {31'd0, valid_out}, 32'd0);
    send_bit(1'b1);
    check("word_valid", {31'd0, valid_out}, 32'd1);
    check("word_data", data_out, 32'hDEADBEEF);
    send_7(COM);
    check("idle_pre_valid", {31'd0, valid_out}, 32'd1);
    send_bit(COM[0]);
    check("idle_valid", {31'd0, valid_out}, 32'd0);
    check("idle_data_hold", data_out, 32'hDEADBEEF);

    // Back-to-back words
    exp_q.push_back(32'h01020304);
    exp_q.push_back(32'hA0B0C0D0);
    send_word(32'h01020304);
    check("b2b_first", data_out, 32'h01020304);
    for (int i = 31; i >= 0; i--) begin
      logic [31:0] w;
      w = 32'hA0B0C0D0;
      send_bit(w[i]);
      check("b2b_valid", {31'd0, valid_out}, 32'd1);
      check("b2b_data", data_out, (i == 0) ? 32'hA0B0C0D0 : 32'h01020304);
    end
    send_byte(COM);
    check("b2b_idle_valid", {31'd0, valid_out}, 32'd0);

    // Aborted word
    exp_q.push_back(32'h33445566);
    send_byte(8'h11); send_byte(8'h22); send_byte(COM);
    check("abort_valid", {31'd0, valid_out}, 32'd0);
    check("abort_hold", data_out, 32'hA0B0C0D0);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    check("abort_word", data_out, 32'h33445566);
    check("abort_word_valid", {31'd0, valid_out}, 32'd1);

    // Asynchronous reset mid-word
    send_byte(8'h77);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #3;
    reset_L = 1'b0;
    #1;
    check("async_rst_data", data_out, 32'd0);
    check("async_rst_valid", {31'd0, valid_out}, 32'd0);
    check("async_rst_active", {31'd0, active}, 32'd0);
    check("async_rst_state", {30'd0, dbg_state}, 32'd0);
    data_in = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    reset_L = 1'b1;

    // Lock failure then relock
    for (int k = 0; k < 3; k++) send_byte(COM);
    send_byte(8'h55);
    check("fail_active", {31'd0, active}, 32'd0);
    check("fail_state", {30'd0, dbg_state}, 32'd0);
    for (int k = 0; k < 3; k++) send_byte(COM);
    check("relock_pre_active", {31'd0, active}, 32'd0);
    send_byte(COM);
    check("relock_active", {31'd0, active}, 32'd1);
    check("relock_valid", {31'd0, valid_out}, 32'd0);
    exp_q.push_back(32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    check("relock_word", data_out, 32'hCAFEF00D);
    send_byte(COM);
    send_byte(COM);

    check("queue_empty", exp_q.size(), 32'd0);
    check("word_count", n_words, 32'd5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
